// File: rtl/spi_sck_gen_pkg.sv
// Shared constants and FSM state type for the SPI serial-clock generator.
package spi_sck_gen_pkg;

  localparam int SPI_DIV_WIDTH = 16;
  localparam int SPI_DLY_WIDTH = 8;
  localparam int SPI_NSS_NUM   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_RUN   = 3'd2,
    ST_TAIL  = 3'd3,
    ST_HOLD  = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_sck_gen_if.sv
// Control/status bundle between the transfer controller and spi_sck_gen.
//
// Handshake: st_i is a single-cycle start request that is accepted only
// when en_i is high and busy_o is low; it is silently dropped otherwise.
// busy_o stays high from the cycle after acceptance until the cycle after
// done_o. done_o is a single-cycle strobe in the last cycle of a transfer
// and never fires for a transfer aborted by en_i going low.
// pos_edge_o/neg_edge_o are single-cycle strobes coincident with the SCK
// register update; core_busy_i is level-sensitive and read only while
// shifting.
interface spi_sck_gen_if
  import spi_sck_gen_pkg::*;
#(
  parameter int DIV_WIDTH = SPI_DIV_WIDTH,
  parameter int DLY_WIDTH = SPI_DLY_WIDTH,
  parameter int CS_NUM    = SPI_NSS_NUM
);

  logic                 en_i;
  logic                 st_i;
  logic                 cpol_i;
  logic [DIV_WIDTH-1:0] div_i;
  logic [DLY_WIDTH-1:0] dly_i;
  logic [CS_NUM-1:0]    nss_sel_i;
  logic                 core_busy_i;

  logic                 spi_clk_o;
  logic                 pos_edge_o;
  logic                 neg_edge_o;
  logic [CS_NUM-1:0]    spi_nss_o;
  logic                 busy_o;
  logic                 done_o;
  spi_state_e           state_o;

  modport slave (
    input  en_i, st_i, cpol_i, div_i, dly_i, nss_sel_i, core_busy_i,
    output spi_clk_o, pos_edge_o, neg_edge_o, spi_nss_o, busy_o, done_o,
           state_o
  );

  modport master (
    output en_i, st_i, cpol_i, div_i, dly_i, nss_sel_i, core_busy_i,
    input  spi_clk_o, pos_edge_o, neg_edge_o, spi_nss_o, busy_o, done_o,
           state_o
  );

endinterface

// File: rtl/spi_clkdiv.sv
// SCK divider: half-period counter, SCK register and edge strobes.
// clear_i has priority over run_i and parks SCK at idle_i with cnt at 0.
module spi_clkdiv
  import spi_sck_gen_pkg::*;
#(
  parameter int DIV_WIDTH = SPI_DIV_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clear_i,
  input  logic                 run_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 idle_i,
  output logic                 tick_o,
  output logic                 spi_clk_o,
  output logic                 pos_edge_o,
  output logic                 neg_edge_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 spi_clk_q, spi_clk_d;

  assign tick_o     = run_i && !clear_i && (cnt_q == div_i);
  assign spi_clk_o  = spi_clk_q;
  assign pos_edge_o = tick_o && !spi_clk_q;
  assign neg_edge_o = tick_o && spi_clk_q;

  // Next counter / SCK value: park, toggle on tick, or count.
  always_comb begin
    cnt_d     = cnt_q;
    spi_clk_d = spi_clk_q;
    if (clear_i) begin
      cnt_d     = '0;
      spi_clk_d = idle_i;
    end else if (tick_o) begin
      cnt_d     = '0;
      spi_clk_d = ~spi_clk_q;
    end else if (run_i) begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end
  end

  // Divider registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q     <= '0;
      spi_clk_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      spi_clk_q <= spi_clk_d;
    end
  end

endmodule

// File: rtl/spi_sck_gen.sv
// SPI serial-clock generator: transfer FSM, chip-select setup/hold delay
// and chip-select register around the spi_clkdiv divider.
module spi_sck_gen
  import spi_sck_gen_pkg::*;
#(
  parameter int DIV_WIDTH = SPI_DIV_WIDTH,
  parameter int DLY_WIDTH = SPI_DLY_WIDTH,
  parameter int CS_NUM    = SPI_NSS_NUM
) (
  input logic          clk_i,
  input logic          rst_n_i,
  spi_sck_gen_if.slave bus
);

  spi_state_e           state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DLY_WIDTH-1:0] dly_q, dly_d;
  logic [DLY_WIDTH-1:0] dly_cnt_q, dly_cnt_d;
  logic                 cpol_q, cpol_d;
  logic [CS_NUM-1:0]    nss_sel_q, nss_sel_d;
  logic                 cs_act_q, cs_act_d;

  logic start;
  logic dly_last;
  logic div_clear, div_run, div_idle;
  logic div_tick, div_clk, div_pos, div_neg;

  // A start is only honoured from IDLE with the block enabled.
  assign start    = bus.en_i && bus.st_i && (state_q == ST_IDLE);
  // Last cycle of a SETUP/HOLD window; a zero delay still spends one HOLD cycle.
  assign dly_last = (dly_q == '0) || (dly_cnt_q == dly_q - DLY_WIDTH'(1));

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; dropping en_i aborts from any state.
  always_comb begin
    state_d = state_q;
    if (!bus.en_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (bus.st_i) state_d = (bus.dly_i == '0) ? ST_RUN : ST_SETUP;
        ST_SETUP: if (dly_last) state_d = ST_RUN;
        ST_RUN:   if (!bus.core_busy_i) state_d = (div_clk == cpol_q) ? ST_HOLD : ST_TAIL;
        ST_TAIL:  if (div_tick) state_d = ST_HOLD;
        ST_HOLD:  if (dly_last) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Divider control: park SCK outside shifting, run while the core is busy,
  // and let the TAIL tick bring SCK back to its idle level.
  always_comb begin
    div_clear = 1'b0;
    div_run   = 1'b0;
    div_idle  = cpol_q;
    if (!bus.en_i || (state_q == ST_IDLE)) begin
      div_clear = 1'b1;
      div_idle  = bus.cpol_i;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.core_busy_i)     div_run   = 1'b1;
          else if (div_clk == cpol_q) div_clear = 1'b1;
        end
        ST_TAIL: div_run   = 1'b1;
        default: div_clear = 1'b1;
      endcase
    end
  end

  // Transfer configuration is captured at the start and frozen until the next one.
  always_comb begin
    div_d     = div_q;
    dly_d     = dly_q;
    cpol_d    = cpol_q;
    nss_sel_d = nss_sel_q;
    if (start) begin
      div_d     = bus.div_i;
      dly_d     = bus.dly_i;
      cpol_d    = bus.cpol_i;
      nss_sel_d = bus.nss_sel_i;
    end
  end

  // Setup/hold delay counter restarts on every state change.
  always_comb begin
    dly_cnt_d = dly_cnt_q;
    if (!bus.en_i || (state_d != state_q)) begin
      dly_cnt_d = '0;
    end else if ((state_q == ST_SETUP) || (state_q == ST_HOLD)) begin
      dly_cnt_d = dly_cnt_q + DLY_WIDTH'(1);
    end
  end

  // Chip-selects assert the cycle after start and release after the last HOLD cycle.
  always_comb begin
    cs_act_d = cs_act_q;
    if (!bus.en_i) begin
      cs_act_d = 1'b0;
    end else if (start) begin
      cs_act_d = 1'b1;
    end else if ((state_q == ST_HOLD) && dly_last) begin
      cs_act_d = 1'b0;
    end
  end

  // Configuration, delay counter and chip-select registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      div_q     <= '0;
      dly_q     <= '0;
      cpol_q    <= 1'b0;
      nss_sel_q <= '0;
      dly_cnt_q <= '0;
      cs_act_q  <= 1'b0;
    end else begin
      div_q     <= div_d;
      dly_q     <= dly_d;
      cpol_q    <= cpol_d;
      nss_sel_q <= nss_sel_d;
      dly_cnt_q <= dly_cnt_d;
      cs_act_q  <= cs_act_d;
    end
  end

  spi_clkdiv #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_clkdiv (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clear_i    (div_clear),
    .run_i      (div_run),
    .div_i      (div_q),
    .idle_i     (div_idle),
    .tick_o     (div_tick),
    .spi_clk_o  (div_clk),
    .pos_edge_o (div_pos),
    .neg_edge_o (div_neg)
  );

  // Outputs; TAIL ticks are deliberately silent towards the core.
  assign bus.spi_clk_o  = div_clk;
  assign bus.pos_edge_o = div_pos && (state_q == ST_RUN);
  assign bus.neg_edge_o = div_neg && (state_q == ST_RUN);
  assign bus.spi_nss_o  = cs_act_q ? ~nss_sel_q : '1;
  assign bus.busy_o     = (state_q != ST_IDLE);
  assign bus.done_o     = bus.en_i && (state_q == ST_HOLD) && dly_last;
  assign bus.state_o    = state_q;

endmodule
